circle_gen: RTL and testbench
=============================

CIRCLE_GEN -- requirements
Module: circle_gen

Interface
REQ-001 SHALL take parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 SHALL take parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 SHALL take parameter XW, default 8, vga_x width; YW, default 7, vga_y width; RW, default 8, radius width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-005 SHALL have the following data ports:
- start input 1: request a draw.
- centre_x input XW+1 signed.
- centre_y input YW+1 signed.
- radius input RW unsigned.
- octant_mask input 8: bit i enables octant i.
- colour input 3.
- plot_ready input 1: pixel sink accepts.
- done output 1.
- busy output 1.
- vga_x output XW.
- vga_y output YW.
- vga_colour output 3.
- vga_plot output 1.

Function
REQ-006 SHALL implement the midpoint circle algorithm:
- init: ox=radius, oy=0, crit=1-radius (signed, RW+2 bits).
- loop while oy<=ox.
- step: oy++; if crit<=0 then crit+=2*oy+1, else ox-- and crit+=2*(oy-ox)+1, using the updated values.
REQ-007 SHALL use FSM states IDLE, INIT, PLOT, STEP, DONE:
- IDLE->INIT on start.
- INIT->PLOT after one cycle.
- PLOT visits octant index 0..7, one per accepted cycle, then goes to STEP.
- STEP->PLOT if oy<=ox after the update, else DONE.
- DONE->IDLE when start is low.
REQ-008 SHALL compute octant coordinates as:
- 0:(cx+ox,cy+oy)
- 1:(cx+oy,cy+ox)
- 2:(cx-ox,cy+oy)
- 3:(cx-oy,cy+ox)
- 4:(cx-ox,cy-oy)
- 5:(cx-oy,cy-ox)
- 6:(cx+ox,cy-oy)
- 7:(cx+oy,cy-ox)
REQ-009 SHALL assert vga_plot in PLOT only if the current octant's mask bit is 1 and the point satisfies 0<=x<SCREEN_W and 0<=y<SCREEN_H; otherwise the point is clipped and vga_plot stays low.
REQ-010 SHALL hold state, coordinates and octant index while vga_plot=1 and plot_ready=0; a masked or clipped octant always advances in one cycle.
REQ-011 SHALL register vga_x, vga_y, vga_colour and vga_plot together.
REQ-012 SHALL capture centre, radius, octant_mask and colour in INIT; input changes during busy are ignored.
REQ-013 SHALL drive busy high in INIT, PLOT and STEP, and low otherwise.
REQ-014 SHALL drive done high only in DONE.
REQ-015 SHALL treat start held high in DONE as no new draw; a new draw needs start low for at least one cycle.
REQ-016 SHALL handle radius=0 as one iteration: 8 PLOT cycles, all at the centre, duplicates permitted.
REQ-017 SHALL handle octant_mask=0 by running the full iteration sequence with vga_plot never asserted, then asserting done.
REQ-018 SHALL compute all coordinate arithmetic at XW+2/YW+2 signed width so that no wrap-around produces a false in-range point.

Reset
REQ-019 SHALL, while rst=1, force:
- state=IDLE
- done=0, busy=0, vga_plot=0
- vga_x=0, vga_y=0, vga_colour=0
- all internal counters to 0
REQ-020 SHALL, on rst mid-draw, abort immediately with no further plots; the next start begins a fresh draw.

Configuration
REQ-021 SHALL, with macro CIRCLE_GEN_CLIP_CNT_EN defined, add output clip_count (16 bits):
- clear it in INIT.
- increment it once per octant with mask bit 1 that is clipped.
- saturate it at 0xFFFF.
- hold it after done.
REQ-022 SHALL, without CIRCLE_GEN_CLIP_CNT_EN, have no clip_count port and no counter logic.

Structure
REQ-023 SHALL import the state enum, the octant index type and the crit width constant from package circle_gen_pkg.
REQ-024 SHALL place the octant coordinate mux and clip compare in sub-module circle_octant_map; the FSM and the iteration registers stay in circle_gen.

Verification
REQ-025 SHALL cover: centre (80,60), r=5, mask 0x01, plot_ready=1 -> exactly 4 plots (85,60),(85,61),(85,62),(84,63), then done=1.
REQ-026 SHALL cover: centre (80,60), r=0, mask 0xFF -> exactly 8 plots, all at (80,60).
REQ-027 SHALL cover: centre (0,0), r=10, mask 0xFF -> no plot with x or y outside the screen; with CIRCLE_GEN_CLIP_CNT_EN, clip_count equals enabled octant points minus plots issued.
REQ-028 SHALL cover: plot_ready low 3 cycles on the 2nd plot -> vga_x/vga_y/vga_plot stable for those cycles; the plot sequence matches the plot_ready=1 run.
REQ-029 SHALL cover: rst pulsed during PLOT -> next cycle vga_plot=0, busy=0, done=0; start then redraws the full sequence.
REQ-030 SHALL cover: start held high after done -> no second draw; start low 1 cycle then high -> new draw.

Source files
------------

// File: rtl/circle_gen_pkg.sv
// Shared types and constants for the midpoint circle generator.
package circle_gen_pkg;

  // Draw sequencer states
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PLOT,
    STEP,
    DONE
  } state_t;

  // Octant index 0..7
  typedef logic [2:0] oct_t;

  // Extra bits on top of the radius width for the midpoint decision term
  localparam int CRIT_PAD = 2;

endpackage

// File: rtl/circle_gen_if.sv
// Request / pixel-sink bundle for circle_gen.
// clip_count exists only when CIRCLE_GEN_CLIP_CNT_EN is defined.
interface circle_gen_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int RW = 8
);
  logic                 start;
  logic signed [XW:0]   centre_x;
  logic signed [YW:0]   centre_y;
  logic [RW-1:0]        radius;
  logic [7:0]           octant_mask;
  logic [2:0]           colour;
  logic                 plot_ready;
  logic                 done;
  logic                 busy;
  logic [XW-1:0]        vga_x;
  logic [YW-1:0]        vga_y;
  logic [2:0]           vga_colour;
  logic                 vga_plot;
`ifdef CIRCLE_GEN_CLIP_CNT_EN
  logic [15:0]          clip_count;
`endif

  // Requester / pixel sink side
  modport master (
    output start, centre_x, centre_y, radius, octant_mask, colour, plot_ready,
    input  done, busy, vga_x, vga_y, vga_colour, vga_plot
`ifdef CIRCLE_GEN_CLIP_CNT_EN
    , input clip_count
`endif
  );

  // Circle generator side
  modport slave (
    input  start, centre_x, centre_y, radius, octant_mask, colour, plot_ready,
    output done, busy, vga_x, vga_y, vga_colour, vga_plot
`ifdef CIRCLE_GEN_CLIP_CNT_EN
    , output clip_count
`endif
  );
endinterface

// File: rtl/circle_octant_map.sv
// Maps the current (ox, oy) iterate onto one of the eight symmetric octant
// points around the centre and checks it against the visible screen.
module circle_octant_map
  import circle_gen_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 8
) (
  input  logic signed [XW:0] cx,
  input  logic signed [YW:0] cy,
  input  logic [RW-1:0]      ox,
  input  logic [RW-1:0]      oy,
  input  oct_t               oct,
  input  logic [7:0]         mask,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               en,
  output logic               in_range
);
  // Wide enough that centre +/- offset can never wrap into the screen
  localparam int AXW = ((XW > RW) ? XW : RW) + 2;
  localparam int AYW = ((YW > RW) ? YW : RW) + 2;

  logic signed [AXW-1:0] base_x, off_x, pos_x;
  logic signed [AYW-1:0] base_y, off_y, pos_y;

  // Pick the octant's offsets and signs, then range-check the point
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path
    // (here unconditionally) so no storage is inferred.
    base_x   = AXW'(cx);
    base_y   = AYW'(cy);
    // Odd octants swap the roles of ox and oy
    off_x    = AXW'(oct[0] ? oy : ox);
    off_y    = AYW'(oct[0] ? ox : oy);
    // Octants 2..5 lie left of the centre, octants 4..7 above it
    pos_x    = (oct[2] ^ oct[1]) ? base_x - off_x : base_x + off_x;
    pos_y    = oct[2] ? base_y - off_y : base_y + off_y;
    in_range = !pos_x[AXW-1] && (pos_x < AXW'(SCREEN_W)) &&
               !pos_y[AYW-1] && (pos_y < AYW'(SCREEN_H));
    en       = mask[oct];
    x        = pos_x[XW-1:0];
    y        = pos_y[YW-1:0];
  end

endmodule

// File: rtl/circle_gen.sv
// Midpoint circle rasteriser: walks one octant of the circle and emits the
// eight mirrored points per step to a ready/plot pixel sink.
// Optional macro CIRCLE_GEN_CLIP_CNT_EN adds a saturating clip_count output.
module circle_gen
  import circle_gen_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 8
) (
  input logic         clk,
  input logic         rst,
  circle_gen_if.slave bus
);
  localparam int CW = RW + CRIT_PAD;

  state_t               state;
  oct_t                 oct;
  logic signed [XW:0]   cx;
  logic signed [YW:0]   cy;
  logic [RW-1:0]        ox, oy;
  logic signed [CW-1:0] crit;
  logic [7:0]           mask;
  logic [2:0]           col;

  logic                 done_q, busy_q, plot_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [2:0]           colour_q;

  logic [XW-1:0]        map_x;
  logic [YW-1:0]        map_y;
  logic                 map_en, map_in;
  logic                 stall;
  logic signed [CW-1:0] ox_s, oy_s, ox_n, oy_n, crit_n;

  circle_octant_map #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .XW(XW), .YW(YW), .RW(RW)
  ) u_map (
    .cx(cx), .cy(cy), .ox(ox), .oy(oy), .oct(oct), .mask(mask),
    .x(map_x), .y(map_y), .en(map_en), .in_range(map_in)
  );

  // A presented pixel the sink has not taken freezes the whole generator
  assign stall = plot_q && !bus.plot_ready;

  // Next midpoint iterate; the crit update uses the already-updated ox/oy
  always_comb begin
    ox_s = $signed({{CRIT_PAD{1'b0}}, ox});
    oy_s = $signed({{CRIT_PAD{1'b0}}, oy});
    oy_n = oy_s + CW'(1);
    ox_n = ox_s;
    crit_n = crit;
    if (crit[CW-1] || (crit == '0)) begin   // crit <= 0
      crit_n = crit + (oy_n <<< 1) + CW'(1);
    end else begin
      ox_n   = ox_s - CW'(1);
      crit_n = crit + ((oy_n - ox_n) <<< 1) + CW'(1);
    end
  end

  // Sequencer, iteration registers and the registered pixel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, captured draw parameters included, is reset so
      // an aborted draw leaves no stale state for the next one.
      state    <= IDLE;
      oct      <= '0;
      cx       <= '0;
      cy       <= '0;
      ox       <= '0;
      oy       <= '0;
      crit     <= '0;
      mask     <= '0;
      col      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else if (!stall) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register here samples the pre-edge values of the others.
      plot_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= INIT;
            busy_q <= 1'b1;
          end
        end
        INIT: begin
          cx    <= bus.centre_x;
          cy    <= bus.centre_y;
          mask  <= bus.octant_mask;
          col   <= bus.colour;
          ox    <= bus.radius;
          oy    <= '0;
          crit  <= CW'(1) - $signed({{CRIT_PAD{1'b0}}, bus.radius});
          oct   <= '0;
          state <= PLOT;
        end
        PLOT: begin
          x_q      <= map_x;
          y_q      <= map_y;
          colour_q <= col;
          plot_q   <= map_en && map_in;
          oct      <= oct + 1'b1;
          if (oct == 3'd7) state <= STEP;
        end
        STEP: begin
          ox   <= ox_n[RW-1:0];
          oy   <= oy_n[RW-1:0];
          crit <= crit_n;
          if (oy_n <= ox_n) begin
            state <= PLOT;
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.start) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.vga_x      = x_q;
  assign bus.vga_y      = y_q;
  assign bus.vga_colour = colour_q;
  assign bus.vga_plot   = plot_q;

`ifdef CIRCLE_GEN_CLIP_CNT_EN
  logic [15:0] clip_cnt;

  // Count enabled octant points that fell off-screen, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt <= '0;
    end else if (!stall) begin
      if (state == INIT) begin
        clip_cnt <= '0;
      end else if (state == PLOT && map_en && !map_in && clip_cnt != 16'hFFFF) begin
        clip_cnt <= clip_cnt + 16'd1;
      end
    end
  end

  assign bus.clip_count = clip_cnt;
`endif

endmodule

// File: tb/tb_circle_gen.sv
// Self-checking bench for circle_gen. A plain-arithmetic midpoint model
// produces the expected pixel list; a negedge process compares every
// accepted pixel. Honours CIRCLE_GEN_CLIP_CNT_EN when defined.
module tb_circle_gen;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int RW = 8;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;

  circle_gen_if #(.XW(XW), .YW(YW), .RW(RW)) bus ();

  circle_gen #(
    .SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW), .RW(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int exp_x[$];
  int exp_y[$];
  int exp_col;
  int en_total;
  int n_model;
  int log_x[$];
  int log_y[$];
  bit check_en = 1'b0;
  int stall_obs;
  bit prev_stall = 1'b0;
  int hold_x, hold_y, hold_p;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixel list straight from the midpoint rules and octant table
  task automatic build_model(input int cx, input int cy, input int r,
                             input logic [7:0] m, input logic [2:0] c);
    int ox, oy, crit, px, py;
    exp_x.delete();
    exp_y.delete();
    log_x.delete();
    log_y.delete();
    en_total = 0;
    exp_col  = int'(c);
    ox = r;
    oy = 0;
    crit = 1 - r;
    while (oy <= ox) begin
      for (int k = 0; k < 8; k++) begin
        px = 0;
        py = 0;
        case (k)
          0: begin px = cx + ox; py = cy + oy; end
          1: begin px = cx + oy; py = cy + ox; end
          2: begin px = cx - ox; py = cy + oy; end
          3: begin px = cx - oy; py = cy + ox; end
          4: begin px = cx - ox; py = cy - oy; end
          5: begin px = cx - oy; py = cy - ox; end
          6: begin px = cx + ox; py = cy - oy; end
          default: begin px = cx + oy; py = cy - ox; end
        endcase
        if (m[k]) begin
          en_total++;
          if (px >= 0 && px < SW && py >= 0 && py < SH) begin
            exp_x.push_back(px);
            exp_y.push_back(py);
          end
        end
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
    n_model = exp_x.size();
  endtask

  // Compare every accepted pixel against the model; check stall stability
  always @(negedge clk) begin
    int ex, ey;
    if (!rst && check_en) begin
      if (prev_stall) begin
        check("stall_hold_x", int'(bus.vga_x), hold_x);
        check("stall_hold_y", int'(bus.vga_y), hold_y);
        check("stall_hold_plot", int'(bus.vga_plot), hold_p);
      end
      prev_stall = 1'b0;
      if (bus.vga_plot && !bus.plot_ready) begin
        prev_stall = 1'b1;
        hold_x = int'(bus.vga_x);
        hold_y = int'(bus.vga_y);
        hold_p = int'(bus.vga_plot);
        stall_obs++;
      end else if (bus.vga_plot) begin
        if (exp_x.size() == 0) begin
          check("extra_plot", log_x.size() + 1, n_model);
        end else begin
          ex = exp_x.pop_front();
          ey = exp_y.pop_front();
          check("plot_x", int'(bus.vga_x), ex);
          check("plot_y", int'(bus.vga_y), ey);
          check("plot_colour", int'(bus.vga_colour), exp_col);
        end
        log_x.push_back(int'(bus.vga_x));
        log_y.push_back(int'(bus.vga_y));
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One complete draw; stall_plot selects the accepted-plot index to hold off
  task automatic run_draw(input int cx, input int cy, input int r,
                          input logic [7:0] m, input logic [2:0] c,
                          input int stall_plot, input bit hold_start);
    int n, seen, stall_left;
    build_model(cx, cy, r, m, c);
    stall_obs = 0;
    bus.centre_x    = (XW + 1)'(cx);
    bus.centre_y    = (YW + 1)'(cy);
    bus.radius      = RW'(r);
    bus.octant_mask = m;
    bus.colour      = c;
    bus.plot_ready  = 1'b1;
    bus.start       = 1'b1;
    check_en        = 1'b1;
    @(posedge clk); #1;
    check("busy_in_init", int'(bus.busy), 1);
    if (!hold_start) bus.start = 1'b0;
    @(posedge clk); #1;
    // Parameters are captured by now; later changes must be ignored
    bus.centre_x    = (XW + 1)'(cx + 37);
    bus.centre_y    = (YW + 1)'(cy - 11);
    bus.radius      = RW'(r + 9);
    bus.octant_mask = ~m;
    bus.colour      = ~c;
    n = 0;
    seen = 0;
    stall_left = 3;
    while (!bus.done && n < 4000) begin
      if (bus.vga_plot) begin
        if (seen == stall_plot && stall_left > 0) begin
          bus.plot_ready = 1'b0;
          stall_left--;
        end else begin
          bus.plot_ready = 1'b1;
          seen++;
        end
      end else begin
        bus.plot_ready = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.plot_ready = 1'b1;
    check("draw_in_budget", int'(n < 4000), 1);
    check("done_at_end", int'(bus.done), 1);
    check("busy_at_end", int'(bus.busy), 0);
    check("plots_left_over", exp_x.size(), 0);
    check("plot_count", log_x.size(), n_model);
`ifdef CIRCLE_GEN_CLIP_CNT_EN
    check("clip_count", int'(bus.clip_count), en_total - log_x.size());
`endif
    if (!hold_start) begin
      @(posedge clk); #1;
      check("idle_after_done", int'(bus.done), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lx[4];
    int ly[4];
    int n;
    lx = '{85, 85, 85, 84};
    ly = '{60, 61, 62, 63};

    bus.start       = 1'b0;
    bus.centre_x    = '0;
    bus.centre_y    = '0;
    bus.radius      = '0;
    bus.octant_mask = '0;
    bus.colour      = '0;
    bus.plot_ready  = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vga_x", int'(bus.vga_x), 0);
    check("rst_vga_y", int'(bus.vga_y), 0);
    check("rst_vga_colour", int'(bus.vga_colour), 0);
    check("rst_vga_plot", int'(bus.vga_plot), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
`ifdef CIRCLE_GEN_CLIP_CNT_EN
    check("rst_clip_count", int'(bus.clip_count), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single octant, r=5: four hand-computed pixels
    run_draw(80, 60, 5, 8'h01, 3'd5, -1, 1'b0);
    check("t1_count", log_x.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_x", (i < log_x.size()) ? log_x[i] : -1, lx[i]);
      check("t1_y", (i < log_y.size()) ? log_y[i] : -1, ly[i]);
    end

    // Zero radius: eight plots, all at the centre
    run_draw(80, 60, 0, 8'hFF, 3'd7, -1, 1'b0);
    check("t2_count", log_x.size(), 8);
    for (int i = 0; i < log_x.size(); i++) begin
      check("t2_x", log_x[i], 80);
      check("t2_y", log_y[i], 60);
    end

    // Corner centre: three quarters of the circle must be clipped
    run_draw(0, 0, 10, 8'hFF, 3'd2, -1, 1'b0);
    for (int i = 0; i < log_x.size(); i++) begin
      check("t3_x_on_screen", int'(log_x[i] < SW), 1);
      check("t3_y_on_screen", int'(log_y[i] < SH), 1);
    end

    // Empty mask: full walk, no plots
    run_draw(80, 60, 3, 8'h00, 3'd1, -1, 1'b0);
    check("t4_no_plots", log_x.size(), 0);

    // Partial mask near the bottom-right edge
    run_draw(155, 115, 8, 8'hA5, 3'd3, -1, 1'b0);

    // Back-pressure: three cycles of plot_ready low on the second plot
    run_draw(80, 60, 5, 8'h01, 3'd5, 1, 1'b0);
    check("t5_stall_cycles", stall_obs, 3);
    check("t5_count", log_x.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t5_x", (i < log_x.size()) ? log_x[i] : -1, lx[i]);
      check("t5_y", (i < log_y.size()) ? log_y[i] : -1, ly[i]);
    end

    // Reset in the middle of a draw, then a fresh full draw
    build_model(80, 60, 20, 8'hFF, 3'd6);
    bus.centre_x    = 9'sd80;
    bus.centre_y    = 8'sd60;
    bus.radius      = 8'd20;
    bus.octant_mask = 8'hFF;
    bus.colour      = 3'd6;
    bus.start       = 1'b1;
    check_en        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (log_x.size() < 5 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_busy", int'(bus.busy), 1);
    check_en = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_plot", int'(bus.vga_plot), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    @(posedge clk); #1;
    check("abort_plot_next", int'(bus.vga_plot), 0);
    check("abort_busy_next", int'(bus.busy), 0);
    check("abort_done_next", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_draw(80, 60, 20, 8'hFF, 3'd6, -1, 1'b0);

    // start held high after done must not retrigger
    run_draw(40, 30, 6, 8'h0F, 3'd4, -1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("held_done", int'(bus.done), 1);
    check("held_busy", int'(bus.busy), 0);
    check("held_no_plots", log_x.size(), n_model);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("released_done", int'(bus.done), 0);
    run_draw(40, 30, 6, 8'h0F, 3'd4, -1, 1'b1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("final_idle", int'(bus.done), 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
